uart_buffered: RTL and testbench

Memory-mapped UART peripheral for the softcore's native memory bus (valid/ready, byte write strobes). It is the buffered successor to the single-byte UART. It adds parametrised TX and RX FIFOs, a runtime baud divisor, optional even/odd parity and sticky error flags. It sits on the CPU data bus beside RAM and the other peripherals, and its `tx`/`rx` pins go to the board's serial bridge.

---
 rtl/uart_buffered.sv | 381 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered.sv
// ============================================================================
// Module   : uart_buffered
// Brief    : Memory-mapped UART with TX/RX FIFOs, runtime baud divisor,
//            optional even/odd parity and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// Circular FIFO; pointers carry one extra wrap bit so full and empty differ.
// ----------------------------------------------------------------------------
module uart_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [c_aw:0]    w_count;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign empty    = (w_count == '0);
    assign full     = (w_count == (c_aw+1)'(DEPTH));
    assign pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

    // Pointer update; full/empty use the pre-cycle count so a push to a full
    // FIFO is dropped even when a pop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop  && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end
endmodule

// ----------------------------------------------------------------------------
// Top level: bus decode, registers, TX and RX engines.
// ----------------------------------------------------------------------------
module uart_buffered #(
    parameter logic [31:0] ADDR       = 32'h0000_0000,
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          BAUDRATE   = 115200,
    parameter int          DATA_BITS  = 8,
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        tx,
    input  logic        rx
);
    localparam logic [15:0] c_reset_div = 16'(CLK_FREQ / BAUDRATE - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    // ---------------- bus / register signals ----------------
    logic        r_ready;
    logic [31:0] r_rdata;
    logic [15:0] r_div;
    logic [1:0]  r_parity;
    logic        r_rx_ovr, r_par_err, r_frame_err, r_tx_ovf;

    logic        w_sel, w_wr;
    logic [1:0]  w_reg;
    logic [7:0]  w_clr;
    logic [31:0] w_status, w_rd_val;
    logic        w_unused;

    // ---------------- FIFO signals ----------------
    logic                 w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
    logic [DATA_BITS-1:0] w_tx_dout;
    logic                 w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic [DATA_BITS-1:0] w_rx_dout;

    // ---------------- TX engine ----------------
    logic [2:0]           r_tx_state;
    logic [15:0]          r_tx_cnt, r_tx_div;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [2:0]           r_tx_idx;
    logic                 r_tx_stop_idx, r_tx_par_en, r_tx_par_bit, r_tx;
    logic                 w_tx_tick, w_tx_last_stop, w_tx_bit;

    // ---------------- RX engine ----------------
    logic                 r_rx_s1, r_rx_s2, r_rx_s3;
    logic [2:0]           r_rx_state;
    logic [15:0]          r_rx_cnt, r_rx_div;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [2:0]           r_rx_idx;
    logic                 r_rx_par_en, r_rx_par_odd;
    logic                 w_rx_fall, w_rx_tick, w_rx_byte_done;
    logic                 w_rx_ovr_set, w_par_err_set, w_frame_err_set;
    logic [15:0]          w_rx_half;

    assign w_unused = &{1'b0, mem_addr[1:0], mem_wdata[31:18]};

    // A new access is accepted only outside the ready cycle, so a master
    // still holding valid during ready does not get a second completion.
    assign w_sel = mem_valid && (mem_addr[31:4] == ADDR[31:4]) && !r_ready;
    assign w_wr  = |mem_wstrb;
    assign w_reg = mem_addr[3:2];
    assign w_clr = (w_sel && w_wr && w_reg == 2'd0) ? mem_wdata[7:0] : 8'h00;

    assign w_tx_push = w_sel && w_wr && (w_reg == 2'd1) && !w_tx_full;
    assign w_rx_pop  = w_sel && !w_wr && (w_reg == 2'd2) && !w_rx_empty;

    assign w_status = {24'h0, r_tx_ovf, r_frame_err, r_par_err, r_rx_ovr,
                       w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

    // Read data mux for the register addressed this cycle.
    always_comb begin
        w_rd_val = 32'h0;
        case (w_reg)
            2'd0:    w_rd_val = w_status;
            2'd1:    w_rd_val = 32'h0;
            2'd2:    w_rd_val = w_rx_empty ? 32'h8000_0000
                                           : {{(32-DATA_BITS){1'b0}}, w_rx_dout};
            default: w_rd_val = {14'h0, r_parity, r_div};
        endcase
    end

    // Bus response: one-cycle ready pulse, read data zero outside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= (w_sel && !w_wr) ? w_rd_val : 32'h0;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;

    // CTRL register with per-byte write strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= c_reset_div;
            r_parity <= 2'b00;
        end else if (w_sel && w_wr && w_reg == 2'd3) begin
            if (mem_wstrb[0]) r_div[7:0]  <= mem_wdata[7:0];
            if (mem_wstrb[1]) r_div[15:8] <= mem_wdata[15:8];
            if (mem_wstrb[2]) r_parity    <= mem_wdata[17:16];
        end
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_ovr    <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_ovf    <= 1'b0;
        end else begin
            r_rx_ovr    <= (r_rx_ovr    & ~w_clr[4]) | w_rx_ovr_set;
            r_par_err   <= (r_par_err   & ~w_clr[5]) | w_par_err_set;
            r_frame_err <= (r_frame_err & ~w_clr[6]) | w_frame_err_set;
            r_tx_ovf    <= (r_tx_ovf    & ~w_clr[7]) |
                           (w_sel && w_wr && w_reg == 2'd1 && w_tx_full);
        end
    end

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_tx_push),
        .push_data (mem_wdata[DATA_BITS-1:0]),
        .pop       (w_tx_pop),
        .pop_data  (w_tx_dout),
        .empty     (w_tx_empty),
        .full      (w_tx_full)
    );

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_rx_push),
        .push_data (r_rx_shift),
        .pop       (w_rx_pop),
        .pop_data  (w_rx_dout),
        .empty     (w_rx_empty),
        .full      (w_rx_full)
    );

    // ---------------- TX engine ----------------
    assign w_tx_tick      = (r_tx_cnt == 16'h0);
    assign w_tx_last_stop = (r_tx_stop_idx == 1'(STOP_BITS - 1));
    // Load a new frame from IDLE, or straight out of the final stop bit so
    // consecutive frames have no idle gap.
    assign w_tx_pop = !w_tx_empty &&
                      ((r_tx_state == c_st_idle) ||
                       (r_tx_state == c_st_stop && w_tx_tick && w_tx_last_stop));

    // Line level for the current state; registered once more into tx.
    always_comb begin
        w_tx_bit = 1'b1;
        case (r_tx_state)
            c_st_start:  w_tx_bit = 1'b0;
            c_st_data:   w_tx_bit = r_tx_shift[0];
            c_st_parity: w_tx_bit = r_tx_par_bit;
            default:     w_tx_bit = 1'b1;
        endcase
    end

    // TX state machine; each state lasts DIV+1 clocks of the latched divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state    <= c_st_idle;
            r_tx_cnt      <= 16'h0;
            r_tx_div      <= 16'h0;
            r_tx_shift    <= '0;
            r_tx_idx      <= 3'd0;
            r_tx_stop_idx <= 1'b0;
            r_tx_par_en   <= 1'b0;
            r_tx_par_bit  <= 1'b0;
            r_tx          <= 1'b1;
        end else begin
            r_tx <= w_tx_bit;
            if (w_tx_pop) begin
                r_tx_state   <= c_st_start;
                r_tx_cnt     <= r_div;
                r_tx_div     <= r_div;
                r_tx_shift   <= w_tx_dout;
                r_tx_par_en  <= (r_parity == 2'b01) || (r_parity == 2'b10);
                r_tx_par_bit <= (^w_tx_dout) ^ (r_parity == 2'b10);
            end else begin
                case (r_tx_state)
                    c_st_idle: ;
                    c_st_start: begin
                        if (w_tx_tick) begin
                            r_tx_state <= c_st_data;
                            r_tx_cnt   <= r_tx_div;
                            r_tx_idx   <= 3'd0;
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    c_st_data: begin
                        if (w_tx_tick) begin
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_cnt   <= r_tx_div;
                            if (r_tx_idx == 3'(DATA_BITS - 1)) begin
                                r_tx_state    <= r_tx_par_en ? c_st_parity : c_st_stop;
                                r_tx_stop_idx <= 1'b0;
                            end else r_tx_idx <= r_tx_idx + 1'b1;
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    c_st_parity: begin
                        if (w_tx_tick) begin
                            r_tx_state    <= c_st_stop;
                            r_tx_cnt      <= r_tx_div;
                            r_tx_stop_idx <= 1'b0;
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    c_st_stop: begin
                        if (w_tx_tick) begin
                            if (w_tx_last_stop) r_tx_state <= c_st_idle;
                            else begin
                                r_tx_stop_idx <= 1'b1;
                                r_tx_cnt      <= r_tx_div;
                            end
                        end else r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                    default: r_tx_state <= c_st_idle;
                endcase
            end
        end
    end

    assign tx = r_tx;

    // ---------------- RX engine ----------------
    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_rx_fall = r_rx_s3 && !r_rx_s2;
    assign w_rx_tick = (r_rx_cnt == 16'h0);
    // (DIV+1)/2 without needing a 17-bit intermediate.
    assign w_rx_half = {1'b0, r_div[15:1]} + {15'h0, r_div[0]};

    assign w_rx_byte_done  = (r_rx_state == c_st_stop) && w_rx_tick && r_rx_s2;
    assign w_rx_push       = w_rx_byte_done && !w_rx_full;
    assign w_rx_ovr_set    = w_rx_byte_done && w_rx_full;
    assign w_frame_err_set = (r_rx_state == c_st_stop) && w_rx_tick && !r_rx_s2;
    assign w_par_err_set   = (r_rx_state == c_st_parity) && w_rx_tick &&
                             (r_rx_s2 != ((^r_rx_shift) ^ r_rx_par_odd));

    // RX state machine: mid-bit sampling from the detected start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state   <= c_st_idle;
            r_rx_cnt     <= 16'h0;
            r_rx_div     <= 16'h0;
            r_rx_shift   <= '0;
            r_rx_idx     <= 3'd0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else begin
            case (r_rx_state)
                c_st_idle: begin
                    if (w_rx_fall) begin
                        r_rx_state   <= c_st_start;
                        r_rx_cnt     <= w_rx_half;
                        r_rx_div     <= r_div;
                        r_rx_par_en  <= (r_parity == 2'b01) || (r_parity == 2'b10);
                        r_rx_par_odd <= (r_parity == 2'b10);
                    end
                end
                c_st_start: begin
                    if (w_rx_tick) begin
                        r_rx_state <= r_rx_s2 ? c_st_idle : c_st_data;
                        r_rx_cnt   <= r_rx_div;
                        r_rx_idx   <= 3'd0;
                    end else r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                c_st_data: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_cnt   <= r_rx_div;
                        if (r_rx_idx == 3'(DATA_BITS - 1))
                            r_rx_state <= r_rx_par_en ? c_st_parity : c_st_stop;
                        else
                            r_rx_idx <= r_rx_idx + 1'b1;
                    end else r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                c_st_parity: begin
                    if (w_rx_tick) begin
                        r_rx_state <= c_st_stop;
                        r_rx_cnt   <= r_rx_div;
                    end else r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                c_st_stop: begin
                    // Only the first stop bit is checked; any second one is
                    // idle-high line time for the edge detector.
                    if (w_rx_tick) r_rx_state <= c_st_idle;
                    else           r_rx_cnt   <= r_rx_cnt - 1'b1;
                end
                default: r_rx_state <= c_st_idle;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_buffered.sv
// ============================================================================
// Module   : tb_uart_buffered
// Brief    : Self-checking bench for uart_buffered (register vectors,
//            loopback scoreboard, parity/framing/glitch/reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_buffered;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        tx;
    logic        rx;
    logic        loop_en = 1'b1;
    logic        ext_rx = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    assign rx = loop_en ? tx : ext_rx;

    uart_buffered dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .tx        (tx),
        .rx        (rx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus access; returns at #1 after the edge that raised mem_ready.
    task automatic bus(input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] q);
        int n;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!mem_ready && n < 8);
        if (!mem_ready) begin
            checks++; errors++;
            $display("FAIL bus_timeout: addr 0x%08h got no ready, expected ready", a);
        end
        q = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic send(input logic [7:0] b, input bit expect_rx);
        logic [31:0] q;
        bus(32'h4, 4'hF, {24'h0, b}, q);
        if (expect_rx) sb.push_back(b);
    endtask

    task automatic receive(input string name);
        logic [31:0] q;
        logic [7:0]  e;
        bus(32'h8, 4'h0, 32'h0, q);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got 0x%08h, expected no pending byte", name, q);
        end else begin
            e = sb.pop_front();
            check(name, q, {24'h0, e});
        end
    endtask

    task automatic reg_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        bus(a, 4'h0, 32'h0, q);
        check(name, q, exp);
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(a, 4'hF, d, q);
    endtask

    // Drive one 8-bit frame on the external rx line, each bit DIV+1 clocks.
    task automatic drive_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                               input bit stop_val, input int div);
        @(negedge clk); ext_rx = 1'b0; repeat (div + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ext_rx = d[i]; repeat (div + 1) @(negedge clk);
        end
        if (par_en) begin
            ext_rx = par_bit; repeat (div + 1) @(negedge clk);
        end
        ext_rx = stop_val; repeat (div + 1) @(negedge clk);
        ext_rx = 1'b1; repeat (div + 1) @(negedge clk);
    endtask

    initial begin
        logic [31:0] q;
        logic        r1, r2, seen;
        int          n;

        vecs[0]  = '{32'h0, 4'h0, 32'h0,         1'b1, 32'h0000_0006};
        vecs[1]  = '{32'hC, 4'h0, 32'h0,         1'b1, 32'h0000_0363};
        vecs[2]  = '{32'h4, 4'h0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[3]  = '{32'h8, 4'h0, 32'h0,         1'b1, 32'h8000_0000};
        vecs[4]  = '{32'hC, 4'h1, 32'hFFFF_FF12, 1'b0, 32'h0};
        vecs[5]  = '{32'hC, 4'h0, 32'h0,         1'b1, 32'h0000_0312};
        vecs[6]  = '{32'hC, 4'h4, 32'h0003_0000, 1'b0, 32'h0};
        vecs[7]  = '{32'hC, 4'h0, 32'h0,         1'b1, 32'h0003_0312};
        vecs[8]  = '{32'hC, 4'hF, 32'h0000_0363, 1'b0, 32'h0};
        vecs[9]  = '{32'h8, 4'hF, 32'h0000_0055, 1'b0, 32'h0};
        vecs[10] = '{32'h0, 4'h0, 32'h0,         1'b1, 32'h0000_0006};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_ready", {31'h0, mem_ready}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Register vectors
        for (int i = 0; i < 11; i++) begin
            bus(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, q);
            if (vecs[i].chk) check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        // Unmapped address: no ready, rdata stays 0
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h100; mem_wstrb = 4'h0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_ready || mem_rdata != 32'h0) seen = 1'b1;
        end
        mem_valid = 1'b0;
        check("unmapped_silent", {31'h0, seen}, 32'h0);

        // Valid held through the ready cycle yields a single ready
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'h0;
        @(posedge clk); #1; r1 = mem_ready;
        @(posedge clk); #1; r2 = mem_ready;
        mem_valid = 1'b0;
        check("ready_first", {31'h0, r1}, 32'h1);
        check("ready_no_repeat", {31'h0, r2}, 32'h0);

        // Loopback at reset divisor (868 clocks per bit)
        send(8'hCE, 1'b1);
        @(posedge clk); #1;
        check("tx_latency_k1", {31'h0, tx}, 32'h1);
        @(posedge clk); #1;
        check("tx_latency_k2", {31'h0, tx}, 32'h0);
        n = 0;
        while (tx == 1'b0 && n < 5000) begin n++; @(posedge clk); #1; end
        check("tx_start_bit0_width", n, 1736);
        n = 0;
        while (tx == 1'b1 && n < 5000) begin n++; @(posedge clk); #1; end
        check("tx_bits123_width", n, 2604);
        send(8'h23, 1'b1);
        repeat (13500) @(posedge clk);
        receive("loop_rx0");
        receive("loop_rx1");
        reg_check("loop_rx_empty", 32'h8, 32'h8000_0000);

        // TX FIFO fill / overflow and RX overrun at DIV=15
        reg_write(32'hC, 32'h0000_000F);
        for (int i = 0; i < 18; i++) send(8'(i), i < 16);
        reg_check("fill_status", 32'h0, 32'h0000_0085);
        repeat (3200) @(posedge clk);
        reg_check("overrun_status", 32'h0, 32'h0000_009A);
        reg_write(32'h0, 32'h0000_0080);
        reg_check("clr_txovf_status", 32'h0, 32'h0000_001A);
        for (int i = 0; i < 16; i++) receive($sformatf("fifo_rx%0d", i));
        reg_check("fifo_rx_empty", 32'h8, 32'h8000_0000);
        reg_write(32'h0, 32'h0000_0010);
        reg_check("clr_ovr_status", 32'h0, 32'h0000_0006);

        // Odd parity loopback at DIV=7
        reg_write(32'hC, 32'h0002_0007);
        send(8'h01, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        check("tx_data_bit0", {31'h0, tx}, 32'h1);
        repeat (64) @(posedge clk);
        #1;
        check("tx_parity_bit", {31'h0, tx}, 32'h0);
        repeat (40) @(posedge clk);
        receive("parity_rx_ok");
        reg_check("parity_ok_status", 32'h0, 32'h0000_0006);

        // External frame with even parity while odd is expected
        loop_en = 1'b0;
        sb.push_back(8'h01);
        drive_frame(8'h01, 1'b1, 1'b1, 1'b1, 7);
        repeat (4) @(posedge clk);
        reg_check("parity_err_status", 32'h0, 32'h0000_0022);
        receive("parity_err_rx");
        reg_write(32'h0, 32'h0000_0020);

        // Framing error: stop bit low, byte discarded
        reg_write(32'hC, 32'h0000_0007);
        drive_frame(8'h55, 1'b0, 1'b0, 1'b0, 7);
        repeat (4) @(posedge clk);
        reg_check("frame_err_status", 32'h0, 32'h0000_0046);
        reg_write(32'h0, 32'h0000_0040);

        // Two-cycle glitch pushes nothing, then a clean frame is received
        @(negedge clk); ext_rx = 1'b0;
        repeat (2) @(negedge clk);
        ext_rx = 1'b1;
        repeat (40) @(posedge clk);
        reg_check("glitch_status", 32'h0, 32'h0000_0006);
        sb.push_back(8'h3C);
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b1, 7);
        repeat (4) @(posedge clk);
        receive("post_glitch_rx");

        // Reset in the middle of a data phase
        loop_en = 1'b1;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check("tx_low_pre_reset", {31'h0, tx}, 32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("tx_after_reset", {31'h0, tx}, 32'h1);
        @(negedge clk); reset = 1'b0;
        reg_check("reset_mid_status", 32'h0, 32'h0000_0006);
        reg_check("reset_mid_ctrl", 32'hC, 32'h0000_0363);
        repeat (20) @(posedge clk);
        #1;
        check("tx_idle_after_reset", {31'h0, tx}, 32'h1);
        sb.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
